adder_share_arb: RTL and testbench

- Round-robin arbiter and sequencer that shares one pipelined 4-bit ripple-carry adder among NREQ requesters.
- Accepts operand requests over per-requester valid/ready handshakes and issues at most one operation per cycle into the adder.
- Tracks the requester ID of each in-flight operation through a tag pipeline matched to the adder latency.
- Returns each sum and carry to the originating requester with a one-hot response valid.

---
 rtl/adder_arb_pkg.sv | 24 ++
 rtl/adder_share_arb_rr_arbiter.sv | 44 ++++
 rtl/adder_share_arb.sv | 150 +++++++++++++++
 tb/tb_adder_share_arb.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : adder_arb_pkg
// Purpose : Shared constants and types for the shared-adder arbiter slice.
//           ADD_WIDTH / ADD_LAT describe the shared ripple-carry adder.
//           NREQ_MAX bounds the requester count, which fixes the tag ID width.
// Ports   : none (package)
// Revision: 1.0  initial release
// ============================================================================
package adder_arb_pkg;

   localparam int ADD_WIDTH = 4;
   localparam int ADD_LAT   = 2;
   localparam int NREQ_MAX  = 8;

   // One entry of the in-flight tag pipeline.
   // The id field is sized for NREQ_MAX requesters.
   typedef struct packed {
      logic       vld;
      logic [2:0] id;
   } tag_t;

endpackage : adder_arb_pkg
`default_nettype wire

// File: rtl/adder_share_arb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter
// Purpose : Combinational round-robin arbiter. The search begins at ptr+1
//           (mod N), so the last winner has the lowest priority.
// Ports   : req_i    [N]     request vector
//           ptr_i    [IDW]   index of the previous winner
//           gnt_o    [N]     one-hot grant (zero when no request is active)
//           gnt_id_o [IDW]   index of the winner (zero when idle)
//           any_o            at least one request is granted
// Revision: 1.0  initial release
// ============================================================================
module rr_arbiter #(
   parameter int N   = 4,
   parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]   req_i,
   input  logic [IDW-1:0] ptr_i,
   output logic [N-1:0]   gnt_o,
   output logic [IDW-1:0] gnt_id_o,
   output logic           any_o
);

   int idx;

   always_comb begin
      gnt_o    = '0;
      gnt_id_o = '0;
      any_o    = 1'b0;
      idx      = 0;
      // Walk the ring once, starting just past the previous winner.
      // The first active request found is the winner.
      for (int k = 1; k <= N; k++) begin
         idx = (int'(ptr_i) + k) % N;
         if (!any_o && req_i[idx]) begin
            any_o      = 1'b1;
            gnt_id_o   = IDW'(idx);
            gnt_o[idx] = 1'b1;
         end
      end
   end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/adder_share_arb.sv
`default_nettype none
// ============================================================================
// Module  : adder_share_arb
// Purpose : Shares one pipelined adder among NREQ requesters.
//           A round-robin grant selects at most one operation per cycle.
//           A LAT-deep tag pipeline routes each sum and carry-out back to
//           the requester that issued it.
// Ports   : clk, rst                 clock, synchronous active-high reset
//           req_valid_i/req_ready_o  per-requester handshake (ready one-hot)
//           req_a_i/req_b_i/req_cin_i packed operands, requester i at
//                                    [i*WIDTH +: WIDTH]
//           add_a_o/add_b_o/add_cin_o operands driven to the shared adder
//           add_s_i/add_cout_i       registered adder results
//           rsp_valid_o/rsp_id_o/rsp_s_o/rsp_cout_o  response to requester
//           stat_ops_o/stat_stall_o  counters, present only when the macro
//                                    ADD_ARB_STATS_EN is defined
// Revision: 1.0  initial release
// ============================================================================
module adder_share_arb
   import adder_arb_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int WIDTH = ADD_WIDTH,
   parameter int LAT   = ADD_LAT,
   parameter int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid_i,
   output logic [NREQ-1:0]       req_ready_o,
   input  logic [NREQ*WIDTH-1:0] req_a_i,
   input  logic [NREQ*WIDTH-1:0] req_b_i,
   input  logic [NREQ-1:0]       req_cin_i,
   output logic [WIDTH-1:0]      add_a_o,
   output logic [WIDTH-1:0]      add_b_o,
   output logic                  add_cin_o,
   input  logic [WIDTH-1:0]      add_s_i,
   input  logic                  add_cout_i,
   output logic [NREQ-1:0]       rsp_valid_o,
   output logic [IDW-1:0]        rsp_id_o,
   output logic [WIDTH-1:0]      rsp_s_o,
   output logic                  rsp_cout_o
`ifdef ADD_ARB_STATS_EN
   ,
   output logic [15:0]           stat_ops_o,
   output logic [15:0]           stat_stall_o
`endif
);

   logic [IDW-1:0] ptr_q, ptr_d;
   logic [NREQ-1:0] gnt;
   logic [IDW-1:0] gnt_id;
   logic           any;
   tag_t           tag_q [LAT];
   tag_t           tag_d;
   tag_t           tag_last;

   rr_arbiter #(
      .N   (NREQ),
      .IDW (IDW)
   ) u_rr_arbiter (
      .req_i    (req_valid_i),
      .ptr_i    (ptr_q),
      .gnt_o    (gnt),
      .gnt_id_o (gnt_id),
      .any_o    (any)
   );

   // The grant only covers valid requesters.
   // A grant therefore always completes a transfer.
   assign req_ready_o = gnt;

   always_comb begin
      add_a_o   = '0;
      add_b_o   = '0;
      add_cin_o = 1'b0;
      if (any) begin
         add_a_o   = req_a_i[int'(gnt_id)*WIDTH +: WIDTH];
         add_b_o   = req_b_i[int'(gnt_id)*WIDTH +: WIDTH];
         add_cin_o = req_cin_i[gnt_id];
      end
   end

   always_comb begin
      ptr_d      = any ? gnt_id : ptr_q;
      tag_d.vld  = any;
      tag_d.id   = 3'(gnt_id);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         // Priority starts with requester 0 after reset.
         ptr_q <= IDW'(NREQ - 1);
         for (int i = 0; i < LAT; i++) tag_q[i] <= '0;
      end else begin
         ptr_q    <= ptr_d;
         tag_q[0] <= tag_d;
         for (int i = 1; i < LAT; i++) tag_q[i] <= tag_q[i-1];
      end
   end

   // The last tag stage lines up with the adder's registered outputs.
   assign tag_last = tag_q[LAT-1];

   always_comb begin
      rsp_valid_o = '0;
      rsp_id_o    = '0;
      rsp_s_o     = '0;
      rsp_cout_o  = 1'b0;
      for (int i = 0; i < NREQ; i++)
         rsp_valid_o[i] = tag_last.vld && (int'(tag_last.id) == i);
      if (tag_last.vld) begin
         rsp_id_o   = IDW'(tag_last.id);
         rsp_s_o    = add_s_i;
         rsp_cout_o = add_cout_i;
      end
   end

`ifdef ADD_ARB_STATS_EN
   logic [15:0] ops_q, ops_d;
   logic [15:0] stall_q, stall_d;

   always_comb begin
      // The ops counter wraps on overflow.
      ops_d   = any ? ops_q + 16'd1 : ops_q;
      stall_d = stall_q;
      // A stall cycle is one where some valid requester is not granted.
      // The stall counter saturates instead of wrapping.
      if (|(req_valid_i & ~gnt) && (stall_q != 16'hFFFF))
         stall_d = stall_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ops_q   <= '0;
         stall_q <= '0;
      end else begin
         ops_q   <= ops_d;
         stall_q <= stall_d;
      end
   end

   assign stat_ops_o   = ops_q;
   assign stat_stall_o = stall_q;
`else
   // No statistics counters in this build.
`endif

endmodule : adder_share_arb
`default_nettype wire

// File: tb/tb_adder_share_arb.sv
`default_nettype none
// ============================================================================
// Module  : tb_adder_share_arb
// Purpose : Self-checking bench for adder_share_arb.
//           The bench models the shared adder and keeps a behavioural
//           arbiter and response model.
// Revision: 1.0  initial release
// ============================================================================
module tb_adder_share_arb;

   localparam int NREQ = 4;
   localparam int W    = 4;
   localparam int LAT  = 2;
   localparam int IDW  = 2;

   logic               clk = 1'b0;
   logic               rst;
   logic [NREQ-1:0]    req_valid, req_ready, req_cin, rsp_valid;
   logic [NREQ*W-1:0]  req_a, req_b;
   logic [W-1:0]       add_a, add_b, rsp_s;
   logic [W-1:0]       add_s = '0;
   logic               add_cin, rsp_cout;
   logic               add_cout = 1'b0;
   logic [IDW-1:0]     rsp_id;
`ifdef ADD_ARB_STATS_EN
   logic [15:0]        stat_ops, stat_stall;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   adder_share_arb #(.NREQ(NREQ), .WIDTH(W), .LAT(LAT)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .req_a_i     (req_a),
      .req_b_i     (req_b),
      .req_cin_i   (req_cin),
      .add_a_o     (add_a),
      .add_b_o     (add_b),
      .add_cin_o   (add_cin),
      .add_s_i     (add_s),
      .add_cout_i  (add_cout),
      .rsp_valid_o (rsp_valid),
      .rsp_id_o    (rsp_id),
      .rsp_s_o     (rsp_s),
      .rsp_cout_o  (rsp_cout)
`ifdef ADD_ARB_STATS_EN
      ,
      .stat_ops_o  (stat_ops),
      .stat_stall_o(stat_stall)
`endif
   );

   // Shared adder with two register stages: an input stage, then an
   // output stage.
   logic [W-1:0] a1 = '0, b1 = '0;
   logic         c1 = 1'b0;
   always @(posedge clk) begin
      a1 <= add_a;
      b1 <= add_b;
      c1 <= add_cin;
      {add_cout, add_s} <= 5'(a1) + 5'(b1) + 5'(c1);
   end

   // Behavioural reference model.
   int m_ptr;
   bit m_vld [LAT];
   int m_id  [LAT];
   int m_s   [LAT];
   int m_c   [LAT];

   function automatic int model_winner(input logic [NREQ-1:0] v);
      for (int k = 1; k <= NREQ; k++) begin
         int i;
         i = (m_ptr + k) % NREQ;
         if (v[i]) return i;
      end
      return -1;
   endfunction

   task automatic model_update();
      int g, tot;
      if (rst) begin
         m_ptr = NREQ - 1;
         for (int i = 0; i < LAT; i++) m_vld[i] = 1'b0;
      end else begin
         for (int i = LAT - 1; i > 0; i--) begin
            m_vld[i] = m_vld[i-1];
            m_id[i]  = m_id[i-1];
            m_s[i]   = m_s[i-1];
            m_c[i]   = m_c[i-1];
         end
         g = model_winner(req_valid);
         m_vld[0] = (g >= 0);
         if (g >= 0) begin
            tot = int'(req_a[g*W +: W]) + int'(req_b[g*W +: W]) + int'(req_cin[g]);
            m_id[0] = g;
            m_s[0]  = tot % 16;
            m_c[0]  = tot / 16;
            m_ptr   = g;
         end
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic set_idle();
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      req_cin   = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      set_idle();
      cyc();
      cyc();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      set_idle();
      cyc();
      cyc();
      #2;
      checks += 5;
      if (rsp_valid !== 4'b0000) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0000", rsp_valid); end
      if (rsp_id !== 2'd0) begin failures++; $display("FAIL reset_rsp_id got=%0d exp=0", rsp_id); end
      if (rsp_s !== 4'h0) begin failures++; $display("FAIL reset_rsp_s got=%h exp=0", rsp_s); end
      if (rsp_cout !== 1'b0) begin failures++; $display("FAIL reset_rsp_cout got=%b exp=0", rsp_cout); end
      if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
      rst = 1'b0;
      cyc();
   endtask

   task automatic test_single();
      do_reset();
      req_valid = 4'b0100;
      req_a[8 +: 4] = 4'd3;
      req_b[8 +: 4] = 4'd4;
      #2;
      checks += 3;
      if (req_ready !== 4'b0100) begin failures++; $display("FAIL single_ready got=%b exp=0100", req_ready); end
      if (add_a !== 4'd3) begin failures++; $display("FAIL single_add_a got=%h exp=3", add_a); end
      if (add_b !== 4'd4) begin failures++; $display("FAIL single_add_b got=%h exp=4", add_b); end
      cyc();
      set_idle();
      #2;
      checks += 2;
      if (rsp_valid !== 4'b0000) begin failures++; $display("FAIL single_early_rsp got=%b exp=0000", rsp_valid); end
      if (add_a !== 4'd0) begin failures++; $display("FAIL idle_add_a got=%h exp=0", add_a); end
      cyc();
      #2;
      checks += 4;
      if (rsp_valid !== 4'b0100) begin failures++; $display("FAIL single_rsp_valid got=%b exp=0100", rsp_valid); end
      if (rsp_id !== 2'd2) begin failures++; $display("FAIL single_rsp_id got=%0d exp=2", rsp_id); end
      if (rsp_s !== 4'd7) begin failures++; $display("FAIL single_rsp_s got=%h exp=7", rsp_s); end
      if (rsp_cout !== 1'b0) begin failures++; $display("FAIL single_rsp_cout got=%b exp=0", rsp_cout); end
      cyc();
   endtask

   task automatic test_fair();
      int es [8];
      int ec [8];
      do_reset();
      for (int k = 0; k < 10; k++) begin
         if (k < 8) begin
            int g, tot;
            req_valid = 4'b1111;
            req_a     = 16'($urandom);
            req_b     = 16'($urandom);
            req_cin   = 4'($urandom);
            g   = k % 4;
            tot = int'(req_a[g*W +: W]) + int'(req_b[g*W +: W]) + int'(req_cin[g]);
            es[k] = tot % 16;
            ec[k] = tot / 16;
         end else begin
            set_idle();
         end
         #2;
         if (k < 8) begin
            checks++;
            if (req_ready !== 4'(1 << (k % 4))) begin
               failures++;
               $display("FAIL fair_grant cyc=%0d got=%b exp=%b", k, req_ready, 4'(1 << (k % 4)));
            end
         end
         if (k >= 2) begin
            checks += 3;
            if (rsp_valid !== 4'(1 << ((k - 2) % 4))) begin
               failures++;
               $display("FAIL fair_rsp cyc=%0d got=%b exp=%b", k, rsp_valid, 4'(1 << ((k - 2) % 4)));
            end
            if (rsp_s !== 4'(es[k-2])) begin failures++; $display("FAIL fair_sum cyc=%0d got=%h exp=%h", k, rsp_s, 4'(es[k-2])); end
            if (rsp_cout !== 1'(ec[k-2])) begin failures++; $display("FAIL fair_cout cyc=%0d got=%b exp=%b", k, rsp_cout, 1'(ec[k-2])); end
         end
         cyc();
      end
   endtask

   task automatic test_overflow();
      set_idle();
      cyc();
      cyc();
      req_valid = 4'b0010;
      req_a[4 +: 4] = 4'hF;
      req_b[4 +: 4] = 4'h1;
      req_cin[1]    = 1'b1;
      cyc();
      set_idle();
      req_valid = 4'b1000;
      req_a[12 +: 4] = 4'h8;
      req_b[12 +: 4] = 4'h7;
      cyc();
      set_idle();
      #2;
      checks += 3;
      if (rsp_valid !== 4'b0010) begin failures++; $display("FAIL ovf_rsp_valid got=%b exp=0010", rsp_valid); end
      if (rsp_s !== 4'h1) begin failures++; $display("FAIL ovf_sum got=%h exp=1", rsp_s); end
      if (rsp_cout !== 1'b1) begin failures++; $display("FAIL ovf_cout got=%b exp=1", rsp_cout); end
      cyc();
      #2;
      checks += 4;
      if (rsp_valid !== 4'b1000) begin failures++; $display("FAIL max_rsp_valid got=%b exp=1000", rsp_valid); end
      if (rsp_id !== 2'd3) begin failures++; $display("FAIL max_rsp_id got=%0d exp=3", rsp_id); end
      if (rsp_s !== 4'hF) begin failures++; $display("FAIL max_sum got=%h exp=F", rsp_s); end
      if (rsp_cout !== 1'b0) begin failures++; $display("FAIL max_cout got=%b exp=0", rsp_cout); end
      cyc();
   endtask

   task automatic test_reset_mid();
      set_idle();
      cyc();
      cyc();
      cyc();
      req_valid = 4'b0001;
      req_a     = 16'($urandom);
      req_b     = 16'($urandom);
      #2;
      checks++;
      if (req_ready !== 4'b0001) begin failures++; $display("FAIL rmid_grant got=%b exp=0001", req_ready); end
      cyc();
      set_idle();
      rst = 1'b1;
      #2;
      checks++;
      if (rsp_valid !== 4'b0000) begin failures++; $display("FAIL rmid_rsp_t1 got=%b exp=0000", rsp_valid); end
      cyc();
      rst = 1'b0;
      #2;
      checks++;
      if (rsp_valid !== 4'b0000) begin failures++; $display("FAIL rmid_rsp_t2 got=%b exp=0000", rsp_valid); end
      cyc();
      req_valid = 4'b1010;
      #2;
      checks += 2;
      if (rsp_valid !== 4'b0000) begin failures++; $display("FAIL rmid_rsp_t3 got=%b exp=0000", rsp_valid); end
      if (req_ready !== 4'b0010) begin failures++; $display("FAIL rmid_first_grant got=%b exp=0010", req_ready); end
      cyc();
      set_idle();
      cyc();
      cyc();
   endtask

   task automatic test_random();
      logic [NREQ-1:0] dir [3];
      dir[0] = 4'b0101;
      dir[1] = 4'b0100;
      dir[2] = 4'b0001;
      do_reset();
      for (int k = 0; k < 40; k++) begin
         int eg;
         logic [NREQ-1:0] exp_rdy, exp_rsp;
         req_valid = (k < 3) ? dir[k] : 4'($urandom);
         req_a     = 16'($urandom);
         req_b     = 16'($urandom);
         req_cin   = 4'($urandom);
         #2;
         eg      = model_winner(req_valid);
         exp_rdy = (eg >= 0) ? 4'(1 << eg) : 4'b0000;
         exp_rsp = m_vld[LAT-1] ? 4'(1 << m_id[LAT-1]) : 4'b0000;
         checks += 2;
         if (req_ready !== exp_rdy) begin failures++; $display("FAIL rand_grant cyc=%0d got=%b exp=%b", k, req_ready, exp_rdy); end
         if (rsp_valid !== exp_rsp) begin failures++; $display("FAIL rand_rsp_valid cyc=%0d got=%b exp=%b", k, rsp_valid, exp_rsp); end
         if (m_vld[LAT-1]) begin
            checks += 3;
            if (rsp_id !== IDW'(m_id[LAT-1])) begin failures++; $display("FAIL rand_rsp_id cyc=%0d got=%0d exp=%0d", k, rsp_id, m_id[LAT-1]); end
            if (rsp_s !== 4'(m_s[LAT-1])) begin failures++; $display("FAIL rand_sum cyc=%0d got=%h exp=%h", k, rsp_s, 4'(m_s[LAT-1])); end
            if (rsp_cout !== 1'(m_c[LAT-1])) begin failures++; $display("FAIL rand_cout cyc=%0d got=%b exp=%b", k, rsp_cout, 1'(m_c[LAT-1])); end
         end else begin
            checks += 2;
            if (rsp_s !== 4'h0) begin failures++; $display("FAIL rand_idle_sum cyc=%0d got=%h exp=0", k, rsp_s); end
            if (rsp_cout !== 1'b0) begin failures++; $display("FAIL rand_idle_cout cyc=%0d got=%b exp=0", k, rsp_cout); end
         end
         cyc();
      end
      set_idle();
      cyc();
      cyc();
   endtask

`ifdef ADD_ARB_STATS_EN
   task automatic test_stats();
      do_reset();
      req_valid = 4'b0111;
      for (int k = 0; k < 5; k++) cyc();
      set_idle();
      #2;
      checks += 2;
      if (stat_ops !== 16'd5) begin failures++; $display("FAIL stat_ops got=%0d exp=5", stat_ops); end
      if (stat_stall !== 16'd5) begin failures++; $display("FAIL stat_stall got=%0d exp=5", stat_stall); end
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      #2;
      checks += 2;
      if (stat_ops !== 16'd0) begin failures++; $display("FAIL stat_ops_rst got=%0d exp=0", stat_ops); end
      if (stat_stall !== 16'd0) begin failures++; $display("FAIL stat_stall_rst got=%0d exp=0", stat_stall); end
      cyc();
   endtask
`endif

   initial begin
      rst   = 1'b1;
      m_ptr = NREQ - 1;
      for (int i = 0; i < LAT; i++) m_vld[i] = 1'b0;
      set_idle();
      #1;
      test_reset();
      test_single();
      test_fair();
      test_overflow();
      test_reset_mid();
      test_random();
`ifdef ADD_ARB_STATS_EN
      test_stats();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_adder_share_arb
`default_nettype wire
